// File: rtl/tty_tx_controller_pkg.sv
// tty_tx_controller_pkg: shared encodings and constants; S_PARITY exists only when TTY_TX_PARITY_EN is defined.
package tty_tx_controller_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_START = 3'd1,
    S_DATA = 3'd2,
`ifdef TTY_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP = 3'd4
  } ser_state_t;
  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_REQ = 2'd1,
    I_SERV = 2'd2
  } irq_state_t;
endpackage

// File: rtl/serial_transmitter.sv
// serial_transmitter: UART 8N1 serializer; TTY_TX_PARITY_EN adds an even-parity bit before the stop bit.
module serial_transmitter
  import tty_tx_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] data,
  input  logic       load,
  output logic       ready,
  output logic       serial,
  output logic       done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  ser_state_t state, state_next;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [7:0] shift;
  logic tick;
  assign tick = timer == TW'(CLKS_PER_BIT - 1);
  assign ready = state == S_IDLE;
  assign done = state == S_STOP && tick;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      timer <= (ready || tick) ? '0 : timer + 1'b1;
      idx <= ready ? '0 : (state == S_DATA && tick) ? idx + 3'd1 : idx;
      if (ready && load) shift <= data;
      else if (state == S_DATA && tick) shift <= shift >> 1;
    end
  end
`ifdef TTY_TX_PARITY_EN
  logic par;
  always_ff @(posedge CLK) begin
    if (RESET) par <= 1'b0;
    else if (ready && load) par <= ^data;
  end
`endif
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = load ? S_START : S_IDLE;
      S_START: state_next = tick ? S_DATA : S_START;
`ifdef TTY_TX_PARITY_EN
      S_DATA: state_next = (tick && idx == 3'd7) ? S_PARITY : S_DATA;
      S_PARITY: state_next = tick ? S_STOP : S_PARITY;
`else
      S_DATA: state_next = (tick && idx == 3'd7) ? S_STOP : S_DATA;
`endif
      S_STOP: state_next = tick ? S_IDLE : S_STOP;
      default: state_next = S_IDLE;
    endcase
  end
  always_comb begin
    serial = STOP_BIT;
    if (state == S_START) serial = START_BIT;
    else if (state == S_DATA) serial = shift[0];
`ifdef TTY_TX_PARITY_EN
    else if (state == S_PARITY) serial = par;
`endif
  end
endmodule

// File: rtl/tty_tx_controller.sv
// tty_tx_controller: byte FIFO feeding a UART serializer, with a drain interrupt handshake.
// Define TTY_TX_PARITY_EN for 11-bit frames with even parity.
module tty_tx_controller
  import tty_tx_controller_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WRITE,
  output logic       TX_FULL,
  output logic       TX_BUSY,
  output logic       INTC_IRQ,
  input  logic       INTC_IACK,
  input  logic       INTC_IEND,
  output logic       OUT_SERIAL_TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic wr, pop, ready, done, drain, pending, pending_next;
  irq_state_t i_state, i_next;
  assign wr = TX_WRITE && !TX_FULL;
  assign pop = ready && count != '0;
  assign count_next = count + CW'(wr) - CW'(pop);
  assign drain = done && count == '0;
  assign INTC_IRQ = i_state == I_REQ;
  serial_transmitter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .CLK(CLK),
    .RESET(RESET),
    .data(mem[rd_ptr]),
    .load(pop),
    .ready(ready),
    .serial(OUT_SERIAL_TX),
    .done(done)
  );
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= TX_DATA;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      TX_FULL <= 1'b0;
      TX_BUSY <= 1'b0;
      i_state <= I_IDLE;
      pending <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_next;
      TX_FULL <= count_next == CW'(FIFO_DEPTH);
      // serializer is busy next cycle unless it is finishing a frame now
      TX_BUSY <= count_next != '0 || pop || (!ready && !done);
      i_state <= i_next;
      pending <= pending_next;
    end
  end
  always_comb begin
    i_next = i_state;
    pending_next = pending;
    case (i_state)
      I_IDLE: begin
        if (drain || pending) begin
          i_next = I_REQ;
          pending_next = 1'b0;
        end
      end
      I_REQ: i_next = INTC_IACK ? I_SERV : I_REQ;
      I_SERV: begin
        i_next = INTC_IEND ? I_IDLE : I_SERV;
        pending_next = pending || drain;
      end
      default: i_next = I_IDLE;
    endcase
  end
endmodule
